// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FETCH_MISALIGN_CHK_EN adds a misaligned flag to each fetch entry.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef struct packed {
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misaligned;
`endif
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; DEPTH must be a power of two so pointers wrap naturally.
// Flush empties the queue and wins over a same-cycle push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output fetch_entry_t             head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en;
  logic            rd_en;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign rd_en = pop & ~empty & ~flush;
  assign wr_en = push & ~flush & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the top masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, credit-based memory requests, prefetch buffering
// and redirect flush. FETCH_MISALIGN_CHK_EN enables the misaligned-redirect entry and stop state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        out_misaligned
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            push;
  logic            pop;
  logic [OccW-1:0] occupancy;
  logic            has_credit;
  logic            fetch_stopped;

`ifdef FETCH_MISALIGN_CHK_EN
  logic stop_q, stop_d;
  logic mis_pend_q, mis_pend_d;
  logic redirect_misaligned;

  assign redirect_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign fetch_stopped       = stop_q;
`else
  assign fetch_stopped = 1'b0;
`endif

  assign pop       = out_valid & out_ready;
  assign out_valid = ~fifo_empty;
  assign im_addr   = fetch_pc_q;

  // Count the in-flight response against capacity so returning data always has a slot.
  always_comb begin
    occupancy  = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop);
    has_credit = (occupancy < OccW'(FIFO_DEPTH));
    im_en      = rst_n & ~redirect_valid & has_credit & ~fetch_stopped;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = im_en;
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_pc_d = redirect_misaligned ? redirect_pc : align_pc(redirect_pc);
`else
      fetch_pc_d = align_pc(redirect_pc);
`endif
    end else if (im_en) begin
      fetch_pc_d = fetch_pc_q + PC_INCR;
      req_pc_d   = fetch_pc_q;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // A misaligned target parks the unaligned PC in fetch_pc and emits one flagged entry.
  always_comb begin
    stop_d     = stop_q;
    mis_pend_d = 1'b0;
    if (redirect_valid) begin
      stop_d     = redirect_misaligned;
      mis_pend_d = redirect_misaligned;
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.misaligned = mis_pend_q;
    push_entry.instr      = mis_pend_q ? 32'h0 : im_rdata;
    push_entry.pc         = mis_pend_q ? fetch_pc_q : req_pc_q;
    push                  = (inflight_q | mis_pend_q) & ~redirect_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_q     <= 1'b0;
      mis_pend_q <= 1'b0;
    end else begin
      stop_q     <= stop_d;
      mis_pend_q <= mis_pend_d;
    end
  end

  assign out_misaligned = fifo_empty ? 1'b0 : fifo_head.misaligned;
`else
  always_comb begin
    push_entry       = '0;
    push_entry.instr = im_rdata;
    push_entry.pc    = req_pc_q;
    push             = inflight_q & ~redirect_valid;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign out_instr = fifo_empty ? 32'h0 : fifo_head.instr;
  assign out_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

  no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC-stream model of the delivered instructions.
// Define FETCH_MISALIGN_CHK_EN to also exercise the misaligned-redirect path.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        im_en;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        out_misaligned;
`else
  logic        out_misaligned;
  assign out_misaligned = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model state: next PC the downstream must receive, plus the misaligned-entry bookkeeping.
  logic [31:0] exp_pc = RPC;
  logic        exp_mis = 1'b0;
  logic        stopped = 1'b0;

  fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_en          (im_en),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .out_misaligned (out_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word content is the inverted address.
  always @(posedge clk) begin
    if (im_en) im_rdata <= im_addr ^ 32'hFFFF_FFFF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc  = RPC;
      exp_mis = 1'b0;
      stopped = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (stopped) begin
          chk("stream_after_stop", {31'd0, out_valid}, 32'd0);
        end else if (exp_mis) begin
          chk("mis_pc", out_pc, exp_pc);
          chk("mis_instr", out_instr, 32'h0);
          chk("mis_flag", {31'd0, out_misaligned}, 32'd1);
          exp_mis = 1'b0;
          stopped = 1'b1;
        end else begin
          chk("stream_pc", out_pc, exp_pc);
          chk("stream_instr", out_instr, ~exp_pc);
          chk("stream_mis", {31'd0, out_misaligned}, 32'd0);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redirect_valid) begin
        stopped = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        if (redirect_pc[1:0] != 2'b00) begin
          exp_mis = 1'b1;
          exp_pc  = redirect_pc;
        end else begin
          exp_mis = 1'b0;
          exp_pc  = redirect_pc & ~32'h3;
        end
`else
        exp_pc = redirect_pc & ~32'h3;
`endif
      end
    end
  end

  // One-cycle reset pulse; returns in the first cycle after release.
  task automatic pulse_reset();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_im_en", {31'd0, im_en}, 32'd0);
    chk("rst_addr", im_addr, RPC);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] target, input logic [31:0] exp_valid_pc);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    chk("redir_im_en", {31'd0, im_en}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("redir1_valid", {31'd0, out_valid}, 32'd0);
    chk("redir1_addr", im_addr, exp_valid_pc);
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cyc();
    cyc();
    #1;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_im_en", {31'd0, im_en}, 32'd0);
    chk("reset_addr", im_addr, RPC);
    chk("reset_instr", out_instr, 32'h0);
    chk("reset_pc", out_pc, 32'h0);

    // Release and stream.
    cyc();
    rst_n = 1'b1;
    #1;
    chk("c0_im_en", {31'd0, im_en}, 32'd1);
    chk("c0_addr", im_addr, RPC);
    chk("c0_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    #1;
    chk("c1_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    #1;
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_pc", out_pc, 32'h8000_0000);
    chk("c2_instr", out_instr, 32'h7FFF_FFFF);
    cyc();
    #1;
    chk("c3_pc", out_pc, 32'h8000_0004);
    chk("c3_instr", out_instr, 32'h7FFF_FFFB);
    for (int i = 0; i < 6; i++) begin
      cyc();
      #1;
      chk("no_bubble", {31'd0, out_valid}, 32'd1);
    end

    // Backpressure for 10 cycles: FIFO fills to depth, fetch stops, head holds.
    cyc();
    out_ready = 1'b0;
    #1;
    chk("stall_im_en0", {31'd0, im_en}, 32'd0);
    chk("stall_head0", out_pc, 32'h8000_0020);
    for (int i = 0; i < 9; i++) begin
      cyc();
      #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_im_en", {31'd0, im_en}, 32'd0);
      chk("stall_head", out_pc, exp_pc);
    end
    cyc();
    out_ready = 1'b1;
    #1;
    chk("resume_im_en", {31'd0, im_en}, 32'd1);
    for (int i = 0; i < 6; i++) cyc();

    // Mid-stream reset, then redirect with FIFO full of 8 and C.
    pulse_reset();
    cyc();
    cyc();
    #1;
    chk("rr_c2_pc", out_pc, RPC);
    cyc();
    cyc();
    out_ready = 1'b0;
    #1;
    chk("a_head", out_pc, 32'h8000_0008);
    cyc();
    #1;
    chk("a_full_im_en", {31'd0, im_en}, 32'd0);
    redirect_to(32'h8000_0100, 32'h8000_0100);
    out_ready = 1'b1;
    chk("a_r1_im_en", {31'd0, im_en}, 32'd1);
    cyc();
    #1;
    chk("a_r2_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    #1;
    chk("a_r3_valid", {31'd0, out_valid}, 32'd1);
    chk("a_r3_pc", out_pc, 32'h8000_0100);
    chk("a_r3_instr", out_instr, 32'h7FFF_FEFF);
    for (int i = 0; i < 4; i++) cyc();

    // Redirect together with the handshake on 8000_0004, while 8 is in flight.
    pulse_reset();
    cyc();
    cyc();
    cyc();
    #1;
    chk("b_head", out_pc, 32'h8000_0004);
    redirect_to(32'h8000_0200, 32'h8000_0200);
    cyc();
    #1;
    chk("b_r2_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    #1;
    chk("b_r3_pc", out_pc, 32'h8000_0200);
    for (int i = 0; i < 4; i++) cyc();

`ifdef FETCH_MISALIGN_CHK_EN
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    #1;
    chk("m_im_en", {31'd0, im_en}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("m1_im_en", {31'd0, im_en}, 32'd0);
    chk("m1_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    #1;
    chk("m2_valid", {31'd0, out_valid}, 32'd1);
    chk("m2_pc", out_pc, 32'h8000_0102);
    chk("m2_flag", {31'd0, out_misaligned}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("m_stopped_im_en", {31'd0, im_en}, 32'd0);
      chk("m_stopped_valid", {31'd0, out_valid}, 32'd0);
    end
    redirect_to(32'h8000_0200, 32'h8000_0200);
    chk("m_resume_im_en", {31'd0, im_en}, 32'd1);
    cyc();
    cyc();
    #1;
    chk("m_resume_pc", out_pc, 32'h8000_0200);
    for (int i = 0; i < 3; i++) cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
